// File: rtl/monta_senha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : monta_senha_pkg
// Description : Shared types (Tipos) for the password assembler. Holds the
//               packed digit buffer type, buffer geometry, pad code, the
//               clear/enter key codes and the assembler FSM state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package monta_senha_pkg;

  localparam int SENHA_MAX_DIGITS = 20;
  localparam int DIGIT_W          = 4;
  localparam int COUNT_W          = 5;

  localparam logic [DIGIT_W-1:0] PAD_CODE  = 4'hF;
  localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;  // '*'
  localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hB;  // '#'

  // digits[0] is the oldest digit and sits in the least significant nibble.
  typedef logic [SENHA_MAX_DIGITS-1:0][DIGIT_W-1:0] senhaPac_t;

  localparam senhaPac_t SENHA_VAZIA = {SENHA_MAX_DIGITS{PAD_CODE}};

  typedef enum logic [1:0] {
    VAZIO     = 2'd0,
    COLETANDO = 2'd1,
    ENVIA     = 2'd2,
    AGUARDA   = 2'd3
  } estado_t;

  function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
    return (code <= 4'h9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/monta_senha_if.sv
`default_nettype none
// ============================================================================
// Module      : monta_senha_if
// Description : Bundle between the keypad side, the password assembler and
//               the password checker.
// Ports       : master - drives key_valid/key_code/verif_done, observes rest
//               slave  - the assembler: receives keys and checker done,
//                        drives senha_teste, valid_out, count, busy,
//                        err_short, timeout_out
// Revision    : 1.0 - initial release
// ============================================================================
interface monta_senha_if;
  import monta_senha_pkg::*;

  logic                       key_valid;
  logic [DIGIT_W-1:0]         key_code;
  logic                       verif_done;
  senhaPac_t                  senha_teste;
  logic                       valid_out;
  logic [COUNT_W-1:0]         count;
  logic                       busy;
  logic                       err_short;
  logic                       timeout_out;

  modport master (
    output key_valid, key_code, verif_done,
    input  senha_teste, valid_out, count, busy, err_short, timeout_out
  );

  modport slave (
    input  key_valid, key_code, verif_done,
    output senha_teste, valid_out, count, busy, err_short, timeout_out
  );

endinterface
`default_nettype wire

// File: rtl/monta_senha_contador_timeout.sv
`default_nettype none
// ============================================================================
// Module      : contador_timeout
// Description : Inactivity counter. Counts enabled cycles; tick_o is high on
//               the TIMEOUT_CYCLES-th consecutive enabled cycle without clear.
// Ports       : clk, rst (async, active-high), clear_i (restart count),
//               enable_i (count this cycle), tick_o (terminal pulse, comb.)
// Revision    : 1.0 - initial release
// ============================================================================
module contador_timeout #(
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear_i,
  input  wire logic enable_i,
  output logic      tick_o
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] cnt_q;

  // Combinational so the FSM can act on the very cycle the limit is reached.
  assign tick_o = enable_i & ~clear_i & (cnt_q == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i || tick_o) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/monta_senha.sv
`default_nettype none
// ============================================================================
// Module      : monta_senha
// Description : Assembles keypad digits into a password buffer, hands it to
//               the checker on enter and waits for the checker to finish.
//               Optional inactivity timeout enabled by MONTA_SENHA_TIMEOUT_EN.
// Ports       : clk, rst (async, active-high)
//               bus (monta_senha_if.slave): key_valid, key_code, verif_done
//               in; senha_teste, valid_out, count, busy, err_short,
//               timeout_out out (all registered, timeout_out tied 0 when
//               the timeout is not built)
// Revision    : 1.0 - initial release
// ============================================================================
module monta_senha
  import monta_senha_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int MIN_DIGITS     = 4
) (
  input wire logic     clk,
  input wire logic     rst,
  monta_senha_if.slave bus
);

  localparam logic [COUNT_W-1:0] c_MIN_DIGITS = COUNT_W'(MIN_DIGITS);
  localparam logic [COUNT_W-1:0] c_MAX_COUNT  = COUNT_W'(SENHA_MAX_DIGITS);

  if (MIN_DIGITS < 1 || MIN_DIGITS > SENHA_MAX_DIGITS || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("monta_senha: MIN_DIGITS or TIMEOUT_CYCLES out of range");
  end

  estado_t            state_q;
  senhaPac_t          digits_q, digits_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               valid_q, busy_q, err_q;
  logic               w_to_tick;

  // Buffer contents after inserting the current key as a digit: append while
  // there is room, otherwise slide the window and drop the oldest digit.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (count_q < c_MAX_COUNT) begin
      digits_d[count_q] = bus.key_code;
      count_d           = count_q + 1'b1;
    end else begin
      digits_d = {bus.key_code, digits_q[SENHA_MAX_DIGITS-1:1]};
    end
  end

`ifdef MONTA_SENHA_TIMEOUT_EN
  logic to_q;
  logic w_key_accept;

  assign w_key_accept = bus.key_valid && (bus.key_code <= KEY_ENTER) &&
                        (state_q == COLETANDO);

  contador_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_contador_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (w_key_accept || (state_q != COLETANDO)),
    .enable_i (state_q == COLETANDO),
    .tick_o   (w_to_tick)
  );

  assign bus.timeout_out = to_q;
`else
  assign w_to_tick       = 1'b0;
  assign bus.timeout_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= VAZIO;
      digits_q <= SENHA_VAZIA;
      count_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef MONTA_SENHA_TIMEOUT_EN
      to_q     <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef MONTA_SENHA_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
      case (state_q)
        VAZIO, COLETANDO: begin
          if (bus.key_valid && is_digit(bus.key_code)) begin
            digits_q <= digits_d;
            count_q  <= count_d;
            state_q  <= COLETANDO;
          end else if (bus.key_valid && bus.key_code == KEY_CLEAR) begin
            digits_q <= SENHA_VAZIA;
            count_q  <= '0;
            state_q  <= VAZIO;
          end else if (bus.key_valid && bus.key_code == KEY_ENTER &&
                       state_q == COLETANDO) begin
            if (count_q < c_MIN_DIGITS) begin
              digits_q <= SENHA_VAZIA;
              count_q  <= '0;
              state_q  <= VAZIO;
              err_q    <= 1'b1;
            end else begin
              state_q  <= ENVIA;
              valid_q  <= 1'b1;
              busy_q   <= 1'b1;
            end
          end else if (w_to_tick) begin
            // Only reachable when no key was accepted this cycle.
            digits_q <= SENHA_VAZIA;
            count_q  <= '0;
            state_q  <= VAZIO;
`ifdef MONTA_SENHA_TIMEOUT_EN
            to_q     <= 1'b1;
`endif
          end
        end
        ENVIA: begin
          state_q <= AGUARDA;
        end
        AGUARDA: begin
          // Keys are never looked at here, so verif_done always wins.
          if (bus.verif_done) begin
            digits_q <= SENHA_VAZIA;
            count_q  <= '0;
            busy_q   <= 1'b0;
            state_q  <= VAZIO;
          end
        end
        default: state_q <= VAZIO;
      endcase
    end
  end

  assign bus.senha_teste = digits_q;
  assign bus.count       = count_q;
  assign bus.valid_out   = valid_q;
  assign bus.busy        = busy_q;
  assign bus.err_short   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_monta_senha.sv
`default_nettype none
// ============================================================================
// Module      : tb_monta_senha
// Description : Self-checking bench for monta_senha. A queue-based reference
//               of the password entry rules predicts every output each cycle.
//               Build with or without MONTA_SENHA_TIMEOUT_EN.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monta_senha;
  import monta_senha_pkg::*;

  localparam int TO  = 16;
  localparam int MIN = 4;
`ifdef MONTA_SENHA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  monta_senha_if ifc ();

  monta_senha #(
    .TIMEOUT_CYCLES (TO),
    .MIN_DIGITS     (MIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Reference: the entered digits as a plain queue, oldest first.
  int m_q[$];
  bit m_send, m_wait;
  int m_idle;
  bit e_valid, e_err, e_to;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic senhaPac_t model_buf();
    senhaPac_t r;
    r = '1;
    for (int i = 0; i < m_q.size(); i++) r[i] = m_q[i][3:0];
    return r;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_idle = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_send = 0; m_wait = 0;
    e_valid = 0; e_err = 0; e_to = 0;
  endtask

  task automatic model_step(input bit kv, input logic [3:0] kc, input bit vd);
    e_valid = 0; e_err = 0; e_to = 0;
    if (m_send) begin
      m_send = 0; m_wait = 1;
    end else if (m_wait) begin
      if (vd) begin model_clear(); m_wait = 0; end
    end else if (kv && kc <= 4'h9) begin
      m_q.push_back(int'(kc));
      if (m_q.size() > 20) void'(m_q.pop_front());
      m_idle = 0;
    end else if (kv && kc == 4'hA) begin
      model_clear();
    end else if (kv && kc == 4'hB && m_q.size() > 0) begin
      if (m_q.size() < MIN) begin
        model_clear(); e_err = 1;
      end else begin
        m_send = 1; e_valid = 1; m_idle = 0;
      end
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (TO_EN && m_idle == TO) begin model_clear(); e_to = 1; end
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".count"},   80'(ifc.count),       80'(m_q.size()));
    check_val({tag, ".senha"},   ifc.senha_teste,      model_buf());
    check_val({tag, ".valid"},   80'(ifc.valid_out),   80'(e_valid));
    check_val({tag, ".busy"},    80'(ifc.busy),        80'(m_send | m_wait));
    check_val({tag, ".err"},     80'(ifc.err_short),   80'(e_err));
    check_val({tag, ".timeout"}, 80'(ifc.timeout_out), 80'(e_to));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input string tag, input bit kv, input logic [3:0] kc, input bit vd);
    ifc.key_valid  = kv;
    ifc.key_code   = kc;
    ifc.verif_done = vd;
    @(posedge clk);
    model_step(kv, kc, vd);
    #1;
    compare_all(tag);
    @(negedge clk);
    ifc.key_valid  = 1'b0;
    ifc.verif_done = 1'b0;
  endtask

  task automatic key(input string tag, input logic [3:0] k);
    cycle(tag, 1'b1, k, 1'b0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ifc.key_valid  = 1'b0;
    ifc.key_code   = 4'h0;
    ifc.verif_done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset("reset");

    // Four digits then enter: one valid_out, busy until verif_done.
    key("pw4", 4'h1); key("pw4", 4'h2); key("pw4", 4'h3); key("pw4", 4'h4);
    key("pw4", 4'hB);
    idle("pw4_wait", 4);
    cycle("pw4_done", 1'b0, 4'h0, 1'b1);
    idle("pw4_after", 1);

    // Too short.
    key("short", 4'h5); key("short", 4'h6); key("short", 4'hB);
    idle("short_after", 1);

    // Enter while empty is ignored.
    key("enter_empty", 4'hB);

    // 21 digits: window of the last 20.
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 10; d++) key("full", 4'(d));
    key("full", 4'h7);
    key("full_clr", 4'hA);

    // Key coinciding with verif_done in AGUARDA is dropped.
    key("coinc", 4'h1); key("coinc", 4'h2); key("coinc", 4'h3); key("coinc", 4'h4);
    key("coinc", 4'hB);
    idle("coinc_wait", 2);
    cycle("coinc_vd", 1'b1, 4'h9, 1'b1);
    idle("coinc_after", 1);

    // Inactivity: key 3 then idle past the limit.
    key("idle", 4'h3);
    idle("idle", TO + 3);
    key("idle_clr", 4'hA);

    // Clear, reserved code, then reset while waiting for the checker.
    key("clr", 4'h1); key("clr", 4'h2); key("clr", 4'h3); key("clr", 4'hA);
    key("rsv", 4'hD);
    key("rsv2", 4'h8); key("rsv2", 4'hE);
    key("rst_aw", 4'h1); key("rst_aw", 4'h2); key("rst_aw", 4'h3); key("rst_aw", 4'h4);
    key("rst_aw", 4'hB);
    idle("rst_aw", 2);
    do_reset("rst_mid");
    idle("rst_after", 2);

    // Randomized traffic with varying key density.
    for (int blk = 0; blk < 20; blk++) begin
      int kp;
      case ($urandom_range(0, 2))
        0:       kp = 3;
        1:       kp = 30;
        default: kp = 75;
      endcase
      for (int c = 0; c < 150; c++) begin
        bit kv, vd;
        logic [3:0] kc;
        int sel;
        kv  = ($urandom_range(0, 99) < kp);
        vd  = ($urandom_range(0, 99) < 15);
        sel = $urandom_range(0, 99);
        if (sel < 75)      kc = 4'($urandom_range(0, 9));
        else if (sel < 82) kc = 4'hA;
        else if (sel < 94) kc = 4'hB;
        else               kc = 4'($urandom_range(12, 15));
        cycle("rand", kv, kc, vd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/monta_senha.md
MONTA_SENHA -- requirements
Module: monta_senha

Interface
REQ-001 The block SHALL have a parameter TIMEOUT_CYCLES, default 250000000, giving the inactivity limit in clk cycles (5 s at 50 MHz).
REQ-002 The block SHALL have a parameter MIN_DIGITS, default 4, giving the minimum digit count accepted on enter.
REQ-003 The block SHALL have port clk, input, 1, system clock (rising edge).
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port key_valid, input, 1, one-cycle strobe qualifying key_code.
REQ-006 The block SHALL have port key_code, input, 4, key value: 0x0-0x9 digit, 0xA clear ('*'), 0xB enter ('#'), 0xC-0xF reserved.
REQ-007 The block SHALL have port verif_done, input, 1, pulse from the password checker ending a check.
REQ-008 The block SHALL have port senha_teste, output, senhaPac_t, the assembled packed digit buffer.
REQ-009 The block SHALL have port valid_out, output, 1, one-cycle pulse marking a new password to check.
REQ-010 The block SHALL have port count, output, 5, number of digits held (0-20).
REQ-011 The block SHALL have port busy, output, 1, high while waiting for the checker.
REQ-012 The block SHALL have port err_short, output, 1, one-cycle pulse when enter is pressed with too few digits.
REQ-013 The block SHALL have port timeout_out, output, 1, one-cycle pulse when the inactivity timeout clears the buffer.

Function
REQ-014 The FSM SHALL have the states VAZIO, COLETANDO, ENVIA and AGUARDA.
REQ-015 A key SHALL be accepted only on a cycle with key_valid=1 in VAZIO or COLETANDO; the effect SHALL be visible on the next cycle.
REQ-016 Digit storage SHALL be in entry order: digits[0] oldest; unfilled positions SHALL read 0xF.
REQ-017 A digit accepted with count<20 SHALL be written at digits[count] and count SHALL increment; state SHALL become COLETANDO.
REQ-018 A digit accepted with count==20 SHALL shift the buffer (oldest dropped, newest at digits[19]) and count SHALL stay 20.
REQ-019 Clear (0xA) SHALL set all digits to 0xF, count to 0 and the state to VAZIO.
REQ-020 Enter (0xB) in VAZIO SHALL be ignored; in COLETANDO with count<MIN_DIGITS it SHALL clear the buffer, go to VAZIO and pulse err_short.
REQ-021 Enter in COLETANDO with count>=MIN_DIGITS SHALL go to ENVIA; valid_out SHALL be 1 for exactly the single ENVIA cycle, followed by AGUARDA.
REQ-022 senha_teste and count SHALL be held stable from ENVIA until leaving AGUARDA; busy SHALL be 1 in ENVIA and AGUARDA.
REQ-023 verif_done in AGUARDA SHALL clear the buffer and go to VAZIO next cycle; verif_done in any other state SHALL be ignored.
REQ-024 Keys in ENVIA/AGUARDA, and reserved codes 0xC-0xF in any state, SHALL be dropped with no side effect.
REQ-025 If key_valid and verif_done coincide in AGUARDA, verif_done SHALL win and the key SHALL be dropped.

Reset
REQ-026 On rst: state VAZIO; digits all 0xF; count 0; valid_out, busy, err_short and timeout_out 0; timeout counter 0.
REQ-027 Reset mid-operation (including AGUARDA) SHALL discard the buffer with no valid_out pulse.

Configuration
REQ-028 With MONTA_SENHA_TIMEOUT_EN defined, TIMEOUT_CYCLES consecutive cycles in COLETANDO with no accepted key SHALL clear the buffer, go to VAZIO and pulse timeout_out; any accepted key SHALL restart the count.
REQ-029 Without MONTA_SENHA_TIMEOUT_EN, no timeout counter SHALL exist and timeout_out SHALL be tied to 0; the port and parameter SHALL remain.

Structure
REQ-030 senhaPac_t, SENHA_MAX_DIGITS=20, the digit width (4), the pad code 0xF and the key codes 0xA/0xB SHALL live in the shared Tipos package.
REQ-031 The inactivity counter SHALL be a sub-module contador_timeout (clear, enable, terminal pulse), instantiated only under MONTA_SENHA_TIMEOUT_EN.

Verification
REQ-032 Keys 1,2,3,4,# -> count=4, digits[0..3]=1,2,3,4, rest 0xF; valid_out=1 for one cycle; busy=1 until verif_done; then count=0.
REQ-033 Keys 5,6,# -> err_short pulse, count=0, no valid_out.
REQ-034 Keys 0..9 twice, then 7 (21 digits) -> count=20, digits[0]=1, digits[19]=7.
REQ-035 Keys 1,2,3,4,# then 9 during AGUARDA, with verif_done in the same cycle as the 9 -> key dropped, buffer cleared, state VAZIO.
REQ-036 With TIMEOUT_CYCLES=16 and the macro defined: key 3 then 16 idle cycles -> timeout_out pulse, count=0; without the macro, count stays 1.
REQ-037 Keys 1,2,3,* then key 0xD -> count=0 after '*', and 0xD leaves the state unchanged; rst asserted in AGUARDA -> all outputs at reset values with no valid_out.
